// File: rtl/mem_bus_pkg.sv
// Shared types for the core/secondary memory bus arbiter.
// Command record layout and default bus widths.
package mem_bus_pkg;

  localparam int unsigned MB_ADDR_W = 32;
  localparam int unsigned MB_DATA_W = 32;

  typedef struct packed {
    logic                 we;
    logic [MB_ADDR_W-1:0] addr;
    logic [MB_DATA_W-1:0] wdata;
  } mb_cmd_t;

  function automatic int unsigned cmd_width(
    input int unsigned aw,
    input int unsigned dw
  );
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_fifo.sv
// Register-based synchronous FIFO for posted secondary commands.
// Pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Core-priority arbiter for a shared single-port synchronous memory.
// Secondary commands are posted and issued only on core-idle cycles.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W       = MB_ADDR_W,
  parameter int unsigned DATA_W       = MB_DATA_W,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd_en,
  input  logic              core_wr_en,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_wdata,
  output logic              s_rvalid,
  output logic [DATA_W-1:0] s_rdata,
  output logic              s_starve,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CMD_W = cmd_width(ADDR_W, DATA_W);
  localparam int unsigned CW    = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NW    = $clog2(DEPTH) + 1;

  logic              w_core_req;
  logic              w_issue;
  logic              w_full;
  logic              w_empty;
  logic [NW-1:0]     w_count;
  logic [CMD_W-1:0]  w_push_data;
  logic [CMD_W-1:0]  w_head;
  logic              w_head_we;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_wdata;
  logic              r_rd_inflight;
  logic [CW-1:0]     r_wait_cnt;

  assign w_push_data  = {s_we, s_addr, s_wdata};
  assign w_head_we    = w_head[CMD_W-1];
  assign w_head_addr  = w_head[DATA_W +: ADDR_W];
  assign w_head_wdata = w_head[DATA_W-1:0];

  assign w_core_req = core_rd_en | core_wr_en;
  assign w_issue    = ~w_core_req & ~w_empty;
  assign s_ready    = ~w_full;

  sync_fifo #(
    .W     (CMD_W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (s_valid & s_ready),
    .i_pop   (w_issue),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Core owns the port outright; the head only fills idle cycles.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = w_head_addr;
    mem_wdata = w_head_wdata;
    if (w_core_req) begin
      mem_rd_en = core_rd_en;
      mem_wr_en = core_wr_en;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (!w_empty) begin
      mem_rd_en = ~w_head_we;
      mem_wr_en = w_head_we;
    end
  end

  assign core_rdata = mem_rdata;
  assign s_rvalid   = r_rd_inflight;
  assign s_rdata    = r_rd_inflight ? mem_rdata : '0;
  assign s_starve   = (r_wait_cnt == CW'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_issue & ~w_head_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (w_empty || w_issue) begin
      r_wait_cnt <= '0;
    end else if (!s_starve) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

  a_count_bound: assert property (
    @(posedge clk) disable iff (!rst_n)
    w_count <= NW'(DEPTH)
  );

endmodule
